cam_readout_arbiter: RTL and testbench

CAM_READOUT_ARBITER -- requirements
Module: cam_readout_arbiter

---
 rtl/cam_readout_arbiter_pkg.sv | 19 +
 rtl/cam_skid_buf.sv | 62 ++++++
 rtl/cam_readout_arbiter.sv | 162 ++++++++++++++++
 tb/tb_cam_readout_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_readout_arbiter_pkg.sv
// Shared imaging package: arbiter state encoding, default burst length and
// overflow counter width, plus a saturating increment for that counter.
package cam_readout_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_BURST  = 2'd2,
        ST_DRAIN  = 2'd3
    } cam_arb_state_e;

    localparam int CAM_BURST_DEFAULT = 16;
    localparam int CAM_OVF_W         = 16;

    function automatic logic [CAM_OVF_W-1:0] ovf_sat_inc(input logic [CAM_OVF_W-1:0] v);
        return (v == '1) ? v : v + CAM_OVF_W'(1);
    endfunction

endpackage

// File: rtl/cam_skid_buf.sv
// Two-entry in-order output buffer.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   push/push_data  write one entry (caller guarantees space)
//   pop             downstream accept; takes effect only when valid
//   valid           buffer non-empty
//   head            oldest entry
//   count           occupancy 0..2
module cam_skid_buf #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] ent0;
    logic [W-1:0] ent1;
    logic [1:0]   cnt;
    logic         pop_fire;

    assign pop_fire = pop && (cnt != 2'd0);
    assign valid    = (cnt != 2'd0);
    assign head     = ent0;
    assign count    = cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({push, pop_fire})
                2'b11: begin
                    // Simultaneous push and pop: occupancy unchanged.
                    if (cnt == 2'd1) begin
                        ent0 <= push_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end
                end
                2'b10: begin
                    if (cnt == 2'd0) ent0 <= push_data;
                    else             ent1 <= push_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cam_readout_arbiter.sv
// Camera FIFO readout arbiter: picks a camera (almost-full priority, else
// round-robin), reads up to BURST words from it with one-cycle FIFO latency,
// and streams them through a 2-entry output buffer tagged with source camera
// and start-of-burst.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   enable                arbitration enable (never aborts a running burst)
//   cam_empty/afull/dout  per-camera FIFO status and read data
//   cam_rden              per-camera read enable, one-hot or zero
//   out_valid/ready/data  output stream; out_cam source, out_sof first word
//   busy                  not idle
//   ovf_cnt               saturating count of cycles with an unserved afull
module cam_readout_arbiter
    import cam_readout_arbiter_pkg::*;
#(
    parameter int NCAM  = 4,
    parameter int DW    = 16,
    parameter int BURST = CAM_BURST_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NCAM-1:0]         cam_empty,
    input  logic [NCAM-1:0]         cam_afull,
    input  logic [NCAM*DW-1:0]      cam_dout,
    output logic [NCAM-1:0]         cam_rden,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW-1:0]           out_data,
    output logic [$clog2(NCAM)-1:0] out_cam,
    output logic                    out_sof,
    output logic                    busy,
    output logic [CAM_OVF_W-1:0]    ovf_cnt
);

    localparam int CW  = $clog2(NCAM);
    localparam int BCW = $clog2(BURST + 1);
    localparam int BW  = 1 + CW + DW;

    cam_arb_state_e state, state_nxt;
    logic [CW-1:0]  grant;
    logic [CW-1:0]  rr_ptr;
    logic [CW-1:0]  sel_idx;
    logic [CW-1:0]  cand;
    logic           sel_found;
    logic [BCW-1:0] issued;
    logic           grant_empty;
    logic           rd_ok;
    logic [1:0]     occ;
    logic [NCAM-1:0] held_mask;
    logic [DW-1:0]  cap_data;
    logic [BW-1:0]  buf_head;

    // Read-return stage: one read in flight, tagged with its camera and sof.
    logic           vld_p1;
    logic           sof_p1;
    logic [CW-1:0]  cam_p1;

    // Afull-with-data has absolute priority by lowest index; otherwise scan
    // round-robin starting just after the last grant. Descending loops leave
    // the lowest index / nearest candidate as the final assignment.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = NCAM - 1; i >= 0; i--) begin
            if (cam_afull[i] && !cam_empty[i]) begin
                sel_found = 1'b1;
                sel_idx   = CW'(i);
            end
        end
        if (!sel_found) begin
            for (int k = NCAM; k >= 1; k--) begin
                cand = CW'((int'(rr_ptr) + k) % NCAM);
                for (int i = 0; i < NCAM; i++) begin
                    if (cand == CW'(i) && !cam_empty[i]) begin
                        sel_found = 1'b1;
                        sel_idx   = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        grant_empty = 1'b1;
        held_mask   = '0;
        cap_data    = '0;
        for (int i = 0; i < NCAM; i++) begin
            if (grant == CW'(i)) begin
                grant_empty = cam_empty[i];
                if (state == ST_BURST || state == ST_DRAIN) held_mask[i] = 1'b1;
            end
            if (cam_p1 == CW'(i)) cap_data = cam_dout[i*DW +: DW];
        end
    end

    // Space check counts the word already in flight so the buffer never overfills.
    assign rd_ok = (state == ST_BURST) && !grant_empty && (issued < BCW'(BURST)) &&
                   ((occ == 2'd0) || ((occ == 2'd1) && !vld_p1));

    always_comb begin
        cam_rden = '0;
        for (int i = 0; i < NCAM; i++) begin
            if (rd_ok && grant == CW'(i)) cam_rden[i] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (enable && (cam_empty != '1)) state_nxt = ST_SELECT;
            ST_SELECT: state_nxt = sel_found ? ST_BURST : ST_IDLE;
            ST_BURST:  if ((issued == BCW'(BURST)) || (grant_empty && !rd_ok)) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (!vld_p1) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            grant   <= '0;
            rr_ptr  <= CW'(NCAM - 1);
            issued  <= '0;
            vld_p1  <= 1'b0;
            sof_p1  <= 1'b0;
            cam_p1  <= '0;
            ovf_cnt <= '0;
        end else begin
            state <= state_nxt;
            // Pointer moves at grant time, so an empty-on-arrival burst still advances it.
            if (state == ST_SELECT && sel_found) begin
                grant  <= sel_idx;
                rr_ptr <= sel_idx;
                issued <= '0;
            end else if (rd_ok) begin
                issued <= issued + BCW'(1);
            end
            vld_p1 <= rd_ok;
            sof_p1 <= rd_ok && (issued == '0);
            cam_p1 <= grant;
            if ((cam_afull & ~held_mask) != '0) ovf_cnt <= ovf_sat_inc(ovf_cnt);
        end
    end

    // Output stage: captured words queue in order behind any stalled head.
    cam_skid_buf #(.W(BW)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (vld_p1),
        .push_data ({sof_p1, cam_p1, cap_data}),
        .pop       (out_ready),
        .valid     (out_valid),
        .head      (buf_head),
        .count     (occ)
    );

    assign {out_sof, out_cam, out_data} = buf_head;
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_cam_readout_arbiter.sv
module tb_cam_readout_arbiter;

    localparam int NCAM = 4;
    localparam int DW   = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic [NCAM-1:0]   cam_empty;
    logic [NCAM-1:0]   cam_afull = '0;
    logic [NCAM*DW-1:0] cam_dout;
    logic [NCAM-1:0]   cam_rden;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_cam;
    logic              out_sof;
    logic              busy;
    logic [15:0]       ovf_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cam_readout_arbiter #(.NCAM(NCAM), .DW(DW), .BURST(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cam_empty (cam_empty),
        .cam_afull (cam_afull),
        .cam_dout  (cam_dout),
        .cam_rden  (cam_rden),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cam   (out_cam),
        .out_sof   (out_sof),
        .busy      (busy),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    // Camera FIFO models: 1-cycle read latency.
    logic [15:0] mem [NCAM][1024];
    int          rd_ptr [NCAM];
    int          wr_ptr [NCAM];
    logic [15:0] dout_r [NCAM];

    always @(posedge clk) begin
        for (int i = 0; i < NCAM; i++) begin
            if (cam_rden[i]) begin
                dout_r[i] <= mem[i][rd_ptr[i]];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    always_comb begin
        cam_empty = '0;
        cam_dout  = '0;
        for (int i = 0; i < NCAM; i++) begin
            cam_empty[i] = (rd_ptr[i] == wr_ptr[i]);
            cam_dout[i*DW +: DW] = dout_r[i];
        end
    end

    // Output log and read-issue bookkeeping, sampled mid-cycle.
    logic [15:0] log_data [512];
    logic [1:0]  log_cam  [512];
    logic        log_sof  [512];
    int          nlog = 0;
    int          rd_seen = 0;
    int          pop_seen = 0;
    int          rden_bad = 0;

    always @(negedge clk) begin
        if (!reset) begin
            rd_seen  <= 0;
            pop_seen <= 0;
        end else begin
            if (cam_rden != '0) begin
                if ((rd_seen - pop_seen) >= 2 || $countones(cam_rden) != 1 ||
                    (cam_rden & cam_empty) != '0)
                    rden_bad <= rden_bad + 1;
                rd_seen <= rd_seen + 1;
            end
            if (out_valid && out_ready && nlog < 512) begin
                log_data[nlog] <= out_data;
                log_cam[nlog]  <= out_cam;
                log_sof[nlog]  <= out_sof;
                nlog           <= nlog + 1;
                pop_seen       <= pop_seen + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int c, input logic [15:0] v);
        mem[c][wr_ptr[c]] = v;
        wr_ptr[c] = wr_ptr[c] + 1;
    endtask

    task automatic wait_words(input int n, input int budget, output bit ok);
        int k;
        k  = 0;
        ok = 1'b1;
        while (nlog < n) begin
            @(negedge clk);
            k++;
            if (k > budget) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int k;
        k  = 0;
        ok = 1'b1;
        @(negedge clk);
        while (busy) begin
            @(negedge clk);
            k++;
            if (k > budget) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b0;
        enable = 1'b0;
        cam_afull = '0;
        out_ready = 1'b1;
        for (int i = 0; i < NCAM; i++) wr_ptr[i] = rd_ptr[i];
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (cam_rden !== 4'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rden=%b busy=%b, required rden=0000 busy=0", cam_rden, busy);
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_sof !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: valid=%b sof=%b, required 0 0", out_valid, out_sof);
        end
        n_checks++;
        if (out_data !== 16'h0 || out_cam !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_data: data=%h cam=%0d, required 0000 0", out_data, out_cam);
        end
        n_checks++;
        if (ovf_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %h required 0000", ovf_cnt);
        end
        reset = 1'b1;
    endtask

    task automatic test_burst_split();
        bit ok;
        int base;
        do_reset();
        enable = 1'b1;
        base = nlog;
        for (int k = 0; k < 20; k++) push_word(0, 16'hA000 + 16'(k));
        wait_words(base + 20, 400, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL split_timeout: got %0d words required 20", nlog - base); end
        wait_idle(100, ok);
        repeat (10) tick();
        n_checks++;
        if (nlog - base != 20) begin n_fail++; $display("FAIL split_count: got %0d required 20", nlog - base); end
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (log_data[base+k] !== 16'hA000 + 16'(k) || log_cam[base+k] !== 2'd0 ||
                log_sof[base+k] !== (k == 0 || k == 16)) begin
                n_fail++;
                $display("FAIL split_word%0d: got data=%h cam=%0d sof=%b required data=%h cam=0 sof=%b",
                         k, log_data[base+k], log_cam[base+k], log_sof[base+k],
                         16'hA000 + 16'(k), (k == 0 || k == 16));
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int base;
        logic [15:0] exp_d;
        do_reset();
        enable = 1'b1;
        base = nlog;
        for (int c = 0; c < NCAM; c++)
            for (int k = 0; k < 3; k++) push_word(c, 16'(c * 4096) + 16'h0B00 + 16'(k));
        wait_words(base + 12, 400, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d words required 12", nlog - base); end
        wait_idle(100, ok);
        for (int j = 0; j < 12; j++) begin
            exp_d = 16'((j / 3) * 4096) + 16'h0B00 + 16'(j % 3);
            n_checks++;
            if (log_data[base+j] !== exp_d || log_cam[base+j] !== 2'(j / 3) ||
                log_sof[base+j] !== (j % 3 == 0)) begin
                n_fail++;
                $display("FAIL rr_word%0d: got data=%h cam=%0d sof=%b required data=%h cam=%0d sof=%b",
                         j, log_data[base+j], log_cam[base+j], log_sof[base+j], exp_d, j / 3, (j % 3 == 0));
            end
        end
    endtask

    task automatic test_afull_priority();
        bit ok;
        int base;
        logic [15:0] exp_d [4];
        logic [1:0]  exp_c [4];
        exp_d = '{16'h3300, 16'h3301, 16'h1100, 16'h1101};
        exp_c = '{2'd3, 2'd3, 2'd1, 2'd1};
        do_reset();
        enable = 1'b1;
        base = nlog;
        push_word(0, 16'h0F00);
        wait_words(base + 1, 100, ok);
        wait_idle(100, ok);
        tick();
        base = nlog;
        push_word(1, 16'h1100);
        push_word(1, 16'h1101);
        push_word(3, 16'h3300);
        push_word(3, 16'h3301);
        cam_afull = 4'b1000;
        wait_words(base + 4, 200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL afull_timeout: got %0d words required 4", nlog - base); end
        wait_idle(100, ok);
        cam_afull = '0;
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (log_data[base+j] !== exp_d[j] || log_cam[base+j] !== exp_c[j] ||
                log_sof[base+j] !== (j % 2 == 0)) begin
                n_fail++;
                $display("FAIL afull_word%0d: got data=%h cam=%0d sof=%b required data=%h cam=%0d sof=%b",
                         j, log_data[base+j], log_cam[base+j], log_sof[base+j], exp_d[j], exp_c[j], (j % 2 == 0));
            end
        end
    endtask

    task automatic test_stall();
        int base;
        int bad0;
        int k;
        do_reset();
        enable = 1'b1;
        base = nlog;
        bad0 = rden_bad;
        for (int j = 0; j < 16; j++) push_word(2, 16'h2C00 + 16'(j));
        k = 0;
        while (k < 400 && !(nlog >= base + 16 && !busy)) begin
            tick();
            out_ready = ~out_ready;
            k++;
        end
        out_ready = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (nlog - base != 16) begin n_fail++; $display("FAIL stall_count: got %0d required 16", nlog - base); end
        n_checks++;
        if (rden_bad != bad0) begin n_fail++; $display("FAIL stall_rden: got %0d bad reads required 0", rden_bad - bad0); end
        for (int j = 0; j < 16; j++) begin
            n_checks++;
            if (log_data[base+j] !== 16'h2C00 + 16'(j) || log_cam[base+j] !== 2'd2 ||
                log_sof[base+j] !== (j == 0)) begin
                n_fail++;
                $display("FAIL stall_word%0d: got data=%h cam=%0d sof=%b required data=%h cam=2 sof=%b",
                         j, log_data[base+j], log_cam[base+j], log_sof[base+j], 16'h2C00 + 16'(j), (j == 0));
            end
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int base;
        do_reset();
        enable = 1'b1;
        base = nlog;
        for (int k = 0; k < 20; k++) push_word(0, 16'h7000 + 16'(k));
        wait_words(base + 3, 100, ok);
        enable = 1'b0;
        wait_words(base + 16, 200, ok);
        wait_idle(100, ok);
        repeat (30) tick();
        n_checks++;
        if (nlog - base != 16 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop: got %0d words busy=%b required 16 words busy=0", nlog - base, busy);
        end
    endtask

    task automatic test_reset_midburst();
        bit ok;
        int base;
        do_reset();
        enable = 1'b1;
        base = nlog;
        for (int k = 0; k < 20; k++) push_word(1, 16'h5100 + 16'(k));
        wait_words(base + 5, 200, ok);
        n_checks++;
        if (!ok || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: words=%0d busy=%b required 5 words busy=1", nlog - base, busy);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (cam_rden !== 4'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_sof !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ctrl: rden=%b valid=%b busy=%b sof=%b required all 0",
                     cam_rden, out_valid, busy, out_sof);
        end
        n_checks++;
        if (out_data !== 16'h0 || out_cam !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_data: data=%h cam=%0d required 0000 0", out_data, out_cam);
        end
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: busy=%b valid=%b required 0 0", busy, out_valid);
        end
        base = nlog;
        wait_words(base + 1, 100, ok);
        n_checks++;
        if (!ok || log_sof[base] !== 1'b1 || log_cam[base] !== 2'd1 || log_data[base] <= 16'h5104) begin
            n_fail++;
            $display("FAIL midrst_fresh: ok=%b sof=%b cam=%0d data=%h required sof=1 cam=1 data>5104",
                     ok, log_sof[base], log_cam[base], log_data[base]);
        end
        wait_words(nlog + 100, 300, ok);
        wait_idle(100, ok);
    endtask

    task automatic test_ovf_sat();
        do_reset();
        tick();
        cam_afull = 4'b0100;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (ovf_cnt !== 16'd10) begin n_fail++; $display("FAIL ovf_count: got %0d required 10", ovf_cnt); end
        repeat (70000) @(posedge clk);
        #1;
        n_checks++;
        if (ovf_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL ovf_sat: got %h required ffff", ovf_cnt); end
        n_checks++;
        if (busy !== 1'b0 || cam_rden !== 4'b0) begin
            n_fail++;
            $display("FAIL ovf_idle: busy=%b rden=%b required 0 0000", busy, cam_rden);
        end
        cam_afull = '0;
    endtask

    initial begin
        test_reset();
        test_burst_split();
        test_round_robin();
        test_afull_priority();
        test_stall();
        test_enable_drop();
        test_reset_midburst();
        test_ovf_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
